// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl
//   Sequences the select of a downstream 16:1 mux over the enabled channels
//   in ascending order and captures the mux output for each channel.
//   Optional feature macro: MUX_SCAN_DWELL_EN adds the dwell port. Each
//   channel then settles for dwell+1 cycles. Without the macro, each channel
//   takes one cycle.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous, active-high reset
//   start     in   scan request, sampled in IDLE only
//   ch_mask   in   [15:0] channel enables, latched at the start edge
//   dwell     in   [3:0] extra settle cycles per channel (MUX_SCAN_DWELL_EN only)
//   y_in      in   downstream mux output
//   sel       out  [3:0] registered mux select
//   busy      out  high while channels are being scanned
//   done      out  one-cycle pulse at scan completion
//   data_out  out  [15:0] captured samples, bit n taken while sel==n
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; sel and data_out hold their last values
// SETTLE | sel driven to one channel; count runs down, sample taken at 0
// DONE   | single-cycle completion pulse, then back to IDLE

module mux16_scan_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] ch_mask,
`ifdef MUX_SCAN_DWELL_EN
   input  logic [3:0]  dwell,
`endif
   input  logic        y_in,
   output logic [3:0]  sel,
   output logic        busy,
   output logic        done,
   output logic [15:0] data_out
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  sel_q, sel_d;
   logic [3:0]  count_q, count_d;
   logic [15:0] mask_q, mask_d;
   logic [15:0] data_q, data_d;

   logic [3:0]  dwell_start;
   logic [3:0]  dwell_held;
   logic [3:0]  first_idx;
   logic [3:0]  nxt_idx;
   logic        has_nxt;

`ifdef MUX_SCAN_DWELL_EN
   logic [3:0]  dwell_q, dwell_d;

   always_ff @(posedge clk) begin
      if (rst) dwell_q <= 4'd0;
      else     dwell_q <= dwell_d;
   end

   always_comb begin
      dwell_d = dwell_q;
      if ((state_q == S_IDLE) && start) dwell_d = dwell;
   end

   assign dwell_start = dwell;
   assign dwell_held  = dwell_q;
`else
   assign dwell_start = 4'd0;
   assign dwell_held  = 4'd0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sel_q   <= 4'd0;
         count_q <= 4'd0;
         mask_q  <= 16'd0;
         data_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         count_q <= count_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
      end
   end

   // Priority search: downward loops leave the lowest qualifying index.
   always_comb begin
      first_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (ch_mask[i]) first_idx = i[3:0];
      end
      nxt_idx = 4'd0;
      has_nxt = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(sel_q))) begin
            nxt_idx = i[3:0];
            has_nxt = 1'b1;
         end
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      count_d = count_q;
      mask_d  = mask_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mask_d = ch_mask;
               data_d = 16'd0;
               if (ch_mask != 16'd0) begin
                  sel_d   = first_idx;
                  count_d = dwell_start;
                  state_d = S_SETTLE;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SETTLE: begin
            if (count_q != 4'd0) begin
               count_d = count_q - 4'd1;
            end else begin
               data_d[sel_q] = y_in;
               if (has_nxt) begin
                  sel_d   = nxt_idx;
                  count_d = dwell_held;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      busy = (state_q == S_SETTLE);
      done = (state_q == S_DONE);
   end

   assign sel      = sel_q;
   assign data_out = data_q;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
module tb_mux16_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] ch_mask;
   logic [3:0]  dwell_v;
   logic        y_in;
   logic [3:0]  sel;
   logic        busy;
   logic        done;
   logic [15:0] data_out;

   logic [15:0] pattern_r;
   logic [3:0]  exp_sel;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   // Behaviour of the downstream 16:1 mux
   always_comb y_in = pattern_r[sel];

   mux16_scan_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ch_mask  (ch_mask),
`ifdef MUX_SCAN_DWELL_EN
      .dwell    (dwell_v),
`endif
      .y_in     (y_in),
      .sel      (sel),
      .busy     (busy),
      .done     (done),
      .data_out (data_out)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected sel per SETTLE cycle: every enabled channel in ascending
   // order, repeated dwell+1 times. Done follows the last entry.
   task automatic run_scan(input logic [15:0] m, input logic [15:0] pat,
                           input logic [3:0] d, input bit perturb);
      int q[$];
      int n;
      for (int i = 0; i < 16; i++)
         if (m[i])
            for (int r = 0; r <= int'(d); r++) q.push_back(i);
      n = q.size();
      pattern_r = pat;
      @(negedge clk);
      ch_mask = m;
      dwell_v = d;
      start   = 1'b1;
      tick();
      start = perturb ? 1'b1 : 1'b0;
      chk("data_clr", data_out, 16'h0000);
      for (int c = 0; c < n; c++) begin
         chk("sel", 16'(sel), 16'(q[c]));
         chk("busy", 16'(busy), 16'h1);
         chk("done_low", 16'(done), 16'h0);
         if (perturb) begin
            start   = 1'($urandom);
            ch_mask = 16'($urandom);
`ifdef MUX_SCAN_DWELL_EN
            dwell_v = 4'($urandom);
`endif
         end
         tick();
      end
      if (n > 0) exp_sel = 4'(q[n-1]);
      chk("done", 16'(done), 16'h1);
      chk("busy_done", 16'(busy), 16'h0);
      chk("sel_done", 16'(sel), 16'(exp_sel));
      chk("data", data_out, m & pat);
      if (perturb) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_end", 16'(done), 16'h0);
      chk("busy_end", 16'(busy), 16'h0);
      chk("sel_hold", 16'(sel), 16'(exp_sel));
      chk("data_hold", data_out, m & pat);
   endtask

   initial begin
      logic [15:0] m;
      logic [3:0]  d;
      bit          found;
      bit          saw_done;
      rst       = 1'b1;
      start     = 1'b0;
      ch_mask   = 16'h0000;
      dwell_v   = 4'd0;
      pattern_r = 16'h0000;
      exp_sel   = 4'd0;
      tick();
      tick();
      chk("rst_sel", 16'(sel), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk("rst_data", data_out, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // Full sweep, one cycle per channel
      run_scan(16'hFFFF, 16'hA5C3, 4'd0, 1'b0);

      // Two end channels with settle time
`ifdef MUX_SCAN_DWELL_EN
      run_scan(16'h8001, 16'hFFFF, 4'd3, 1'b0);
`else
      run_scan(16'h8001, 16'hFFFF, 4'd0, 1'b0);
`endif

      // Empty mask
      run_scan(16'h0000, 16'hFFFF, 4'd0, 1'b0);

      // Start and mask changes during a scan are ignored
      run_scan(16'h0F00, 16'h0A00, 4'd0, 1'b1);

      run_scan(16'h0011, 16'h0010, 4'd0, 1'b0);

      // Reset mid-scan
      pattern_r = 16'h00F0;
      @(negedge clk);
      ch_mask = 16'h00F0;
      dwell_v = 4'd0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (sel == 4'd5) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("reach_sel5", 16'(found), 16'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_sel = 4'd0;
      chk("abort_sel", 16'(sel), 16'h0);
      chk("abort_busy", 16'(busy), 16'h0);
      chk("abort_data", data_out, 16'h0000);
      chk("abort_done", 16'(done), 16'h0);
      saw_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done || busy) saw_done = 1'b1;
         tick();
      end
      chk("abort_quiet", 16'(saw_done), 16'h0);

      // Reset wins over start
      @(negedge clk);
      rst     = 1'b1;
      start   = 1'b1;
      ch_mask = 16'hFFFF;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk("prio_busy", 16'(busy), 16'h0);
      chk("prio_sel", 16'(sel), 16'h0);
      tick();
      chk("prio_idle", 16'(busy), 16'h0);
      chk("prio_nodone", 16'(done), 16'h0);

      // Randomized scans against the reference sequence
      for (int t = 0; t < 24; t++) begin
         m = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       m = 16'h0000;
            1, 2:    m = m & 16'($urandom);
            default: ;
         endcase
`ifdef MUX_SCAN_DWELL_EN
         d = 4'($urandom_range(0, 3));
`else
         d = 4'd0;
`endif
         run_scan(m, 16'($urandom), d, bit'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
